des_round_engine: RTL and testbench

DES_ROUND_ENGINE -- requirements
Module: des_round_engine

---
 rtl/des_round_engine.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_des_round_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel core, one round per clock,
// on-the-fly key schedule, valid/ready handshake on both sides.
module des_round_engine #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_text,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_text
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

  // bit n-1 set when round n rotates by two positions
  localparam logic [15:0] TWO_TAB = 16'h7EFC;

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,
     6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27,
    28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1,
    58, 50, 42, 34, 26, 18, 10,  2,
    59, 51, 43, 35, 27, 19, 11,  3,
    60, 52, 44, 36, 63, 55, 47, 39,
    31, 23, 15,  7, 62, 54, 46, 38,
    30, 22, 14,  6, 61, 53, 45, 37,
    29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28,
    15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56,
    34, 53, 46, 42, 50, 36, 29, 32
  };

  // S1..S8, 64 entries each, index = row*16 + col
  localparam int S_TAB [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  function automatic logic [47:0] f_expand(
    input logic [31:0] r
  );
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++)
      o[6'(47 - i)] = r[5'(32 - E_TAB[i])];
    return o;
  endfunction

  function automatic logic [31:0] f_perm(
    input logic [31:0] s
  );
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++)
      o[5'(31 - i)] = s[5'(32 - P_TAB[i])];
    return o;
  endfunction

  function automatic logic [55:0] f_pc1(
    input logic [63:0] k
  );
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++)
      o[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return o;
  endfunction

  function automatic logic [47:0] f_pc2(
    input logic [55:0] cd
  );
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++)
      o[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return o;
  endfunction

  function automatic logic [31:0] f_sbox(
    input logic [47:0] x
  );
    logic [31:0] o;
    logic [5:0]  b;
    o = '0;
    for (int s = 0; s < 8; s++) begin
      b = x[6'(42 - 6 * s) +: 6];
      o[5'(28 - 4 * s) +: 4] = 4'(S_TAB[
        {s[2:0], b[5], b[0], b[4:1]}]);
    end
    return o;
  endfunction

  function automatic logic [27:0] f_rol(
    input logic [27:0] c,
    input logic        two
  );
    return two ? {c[25:0], c[27:26]}
               : {c[26:0], c[27]};
  endfunction

  function automatic logic [27:0] f_ror(
    input logic [27:0] c,
    input logic        two
  );
    return two ? {c[1:0], c[27:2]}
               : {c[0], c[27:1]};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ready;
  logic        r_valid;
  logic [63:0] r_text;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic        r_dec;
  logic [4:0]  r_cnt;

  logic        w_accept;
  logic        w_last;
  logic [3:0]  w_didx;
  logic        w_two;
  logic [27:0] w_c_nxt;
  logic [27:0] w_d_nxt;
  logic [47:0] w_k;
  logic [31:0] w_f;
  logic [31:0] w_l_nxt;
  logic [31:0] w_r_nxt;
  logic [55:0] w_cd0;

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_text   = r_text;

  assign w_accept = (r_state == S_IDLE)
                  && i_valid && r_ready;
  assign w_last   = (r_cnt == LAST);
  assign w_didx   = 4'd0 - r_cnt[3:0];
  assign w_cd0    = f_pc1(i_key);

  // key rotation for the round about to run
  always_comb begin
    w_two   = 1'b0;
    w_c_nxt = r_c;
    w_d_nxt = r_d;
    if (!r_dec) begin
      w_two   = TWO_TAB[r_cnt[3:0]];
      w_c_nxt = f_rol(r_c, w_two);
      w_d_nxt = f_rol(r_d, w_two);
    end else if (r_cnt != 5'd0) begin
      w_two   = TWO_TAB[w_didx];
      w_c_nxt = f_ror(r_c, w_two);
      w_d_nxt = f_ror(r_d, w_two);
    end
  end

  assign w_k     = f_pc2({w_c_nxt, w_d_nxt});
  assign w_f     = f_perm(f_sbox(f_expand(r_r) ^ w_k));
  assign w_l_nxt = r_r;
  assign w_r_nxt = r_l ^ w_f;

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_valid && r_ready)
          w_state_nxt = S_ROUND;
      S_ROUND:
        if (w_last)
          w_state_nxt = S_DONE;
      S_DONE:
        if (i_ready)
          w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  // state register with registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_valid <= (w_state_nxt == S_DONE);
    end
  end

  // block load, round iteration and result capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_l    <= '0;
      r_r    <= '0;
      r_c    <= '0;
      r_d    <= '0;
      r_dec  <= 1'b0;
      r_cnt  <= '0;
      r_text <= '0;
    end else if (w_accept) begin
      r_l   <= i_text[63:32];
      r_r   <= i_text[31:0];
      r_dec <= i_decrypt;
      r_c   <= w_cd0[55:28];
      r_d   <= w_cd0[27:0];
      r_cnt <= '0;
    end else if (r_state == S_ROUND) begin
      r_l <= w_l_nxt;
      r_r <= w_r_nxt;
      r_c <= w_c_nxt;
      r_d <= w_d_nxt;
      if (w_last)
        r_text <= {w_r_nxt, w_l_nxt};
      else
        r_cnt <= r_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed vectors for the DES round engine,
// checked against a whole-block DES reference and a cycle model.
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_text;
  logic [63:0] i_key;
  logic        i_decrypt;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_text;

  always #5 clk = ~clk;

  des_round_engine #(.NUM_ROUNDS(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_text    (i_text),
    .i_key     (i_key),
    .i_decrypt (i_decrypt),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_text    (o_text)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] CT  = 64'h0A4CD99543423234;
  localparam logic [63:0] RT  = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] TA  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KA  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] TB  = 64'hDEADBEEF01234567;
  localparam logic [63:0] KB  = 64'hFEDCBA9876543210;

  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int E_T [48] = '{
    32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,
    30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,
    27,19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,
    30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,
    13,2,41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,
    46,42,50,36,29,32};
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [47:0] subkey(input logic [63:0] k, input int n);
    logic [63:0] t;
    logic [55:0] cd;
    logic [47:0] o;
    logic [27:0] c, d;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      t = k >> (64 - PC1_T[i]);
      cd = {cd[54:0], t[0]};
    end
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < n; i++)
      for (int j = 0; j < SH_T[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    o = '0;
    for (int i = 0; i < 48; i++) begin
      t = 64'({c, d}) >> (56 - PC2_T[i]);
      o = {o[46:0], t[0]};
    end
    return o;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e, t48;
    logic [31:0] s, o, t;
    logic [5:0]  six;
    int row, col;
    e = '0;
    for (int i = 0; i < 48; i++) begin
      t = r >> (32 - E_T[i]);
      e = {e[46:0], t[0]};
    end
    e = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      t48 = e >> (42 - 6 * b);
      six = t48[5:0];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s = (s << 4) | 32'(S_T[b][row * 16 + col]);
    end
    o = '0;
    for (int i = 0; i < 32; i++) begin
      t = s >> (32 - P_T[i]);
      o = {o[30:0], t[0]};
    end
    return o;
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] txt, input logic [63:0] k, input bit dec);
    logic [47:0] ks [1:16];
    logic [31:0] l, r, tmp;
    for (int i = 1; i <= 16; i++) ks[i] = subkey(k, i);
    l = txt[63:32];
    r = txt[31:0];
    for (int i = 1; i <= 16; i++) begin
      tmp = r;
      r = l ^ feistel(r, dec ? ks[17 - i] : ks[i]);
      l = tmp;
    end
    return {r, l};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // cycle-level model: idle -> 16 busy cycles -> hold result until taken
  logic        m_rdy = 1'b0;
  logic        m_vld = 1'b0;
  logic [63:0] m_text = '0;
  logic [63:0] m_res = '0;
  int          m_busy = 0;
  int          m_acc = 0;
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    m_on = 1'b1;
    if (!rst_n) begin
      m_rdy = 1'b0; m_vld = 1'b0; m_text = '0; m_busy = 0;
    end else if (m_rdy && i_valid) begin
      m_rdy = 1'b0;
      m_busy = 16;
      m_res = des_model(i_text, i_key, i_decrypt);
      m_acc++;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_vld = 1'b1; m_text = m_res; end
    end else if (m_vld) begin
      if (i_ready) begin m_vld = 1'b0; m_rdy = 1'b1; end
    end else begin
      m_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("cyc_o_ready", 64'(o_ready), 64'(m_rdy));
      chk("cyc_o_valid", 64'(o_valid), 64'(m_vld));
      chk("cyc_o_text", o_text, m_text);
    end
  end

  task automatic send(input logic [63:0] t, input logic [63:0] k, input bit d, input bit hold);
    int a0 = m_acc;
    int n = 0;
    i_text = t; i_key = k; i_decrypt = d; i_valid = 1'b1;
    while (m_acc == a0 && n < 50) begin @(negedge clk); n++; end
    if (m_acc == a0) begin
      errors++; checks++;
      $display("FAIL send_accept: not accepted after %0d cycles, required acceptance", n);
    end
    if (!hold) begin
      i_valid = 1'b0; i_text = ~t; i_key = ~k; i_decrypt = ~d;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 60) begin @(negedge clk); n++; end
    if (!o_valid) begin
      errors++; checks++;
      $display("FAIL wait_valid: o_valid 0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int lat, seen, n, a0;
    rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
    i_decrypt = 1'b0; i_text = '1; i_key = '1;
    repeat (3) @(negedge clk);
    chk("rst_o_ready", 64'(o_ready), 64'd0);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_text", o_text, 64'd0);
    i_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(o_ready), 64'd1);

    chk("model_k1", 64'(subkey(KEY, 1)), 64'h1B02EFFC7072);
    chk("model_enc", des_model(PT, KEY, 1'b0), CT);
    chk("model_dec", des_model(CT, KEY, 1'b1), RT);

    send(PT, KEY, 1'b0, 1'b0);
    wait_valid(lat);
    chk("enc_latency", 64'(lat), 64'd16);
    chk("enc_text", o_text, CT);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_text", o_text, CT);
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 64'(o_valid), 64'd0);
    chk("release_ready", 64'(o_ready), 64'd1);

    send(CT, KEY, 1'b1, 1'b0);
    wait_valid(lat);
    chk("dec_latency", 64'(lat), 64'd16);
    chk("dec_text", o_text, RT);
    @(negedge clk);

    send(TA, KA, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    i_valid = 1'b1; i_text = TB; i_key = KB; i_decrypt = 1'b1;
    repeat (2) @(negedge clk);
    i_valid = 1'b0;
    wait_valid(lat);
    chk("busy_latency", 64'(lat), 64'd10);
    chk("busy_text", o_text, des_model(TA, KA, 1'b0));
    @(negedge clk);

    send(TB, KB, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    chk("abort_ready", 64'(o_ready), 64'd1);
    send(TA, KA, 1'b1, 1'b0);
    wait_valid(lat);
    chk("post_rst_text", o_text, des_model(TA, KA, 1'b1));
    @(negedge clk);

    i_ready = 1'b1;
    send(TA, KEY, 1'b0, 1'b1);
    i_text = TB; i_key = KA; i_decrypt = 1'b1;
    wait_valid(lat);
    chk("b2b_1_text", o_text, des_model(TA, KEY, 1'b0));
    a0 = m_acc; n = 0;
    while (m_acc == a0 && n < 10) begin @(negedge clk); n++; end
    chk("b2b_accept_gap", 64'(n), 64'd2);
    i_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_2_latency", 64'(lat), 64'd16);
    chk("b2b_2_text", o_text, des_model(TB, KA, 1'b1));
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
